// File: rtl/game_pkg.sv
// Shared types and constants for the room sequencer and its neighbours
// (sprite/enemy movers, colour mapper).
package game_pkg;

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        FADE_OUT = 2'd1,
        SWAP     = 2'd2,
        FADE_IN  = 2'd3
    } room_state_t;

    typedef enum logic {
        DIR_L = 1'b0,
        DIR_R = 1'b1
    } dir_t;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int NUM_ENEMIES = 3;
    localparam int MAX_ROOMS   = 4;

    // Inclusive unsigned window test used for the door opening.
    function automatic logic in_window(input logic [9:0] v,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/fade_counter.sv
// Saturating up/down fade-level counter; also reused by the colour mapper.
module fade_counter #(
    parameter int MAX_LEVEL = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] level,
    output logic       at_max,
    output logic       at_zero
);

    localparam logic [3:0] MAX_L = 4'(MAX_LEVEL);

    logic [3:0] level_q;
    logic [3:0] level_d;

    assign level   = level_q;
    assign at_max  = (level_q == MAX_L);
    assign at_zero = (level_q == 4'd0);

    // Next level: increment wins over decrement; both saturate.
    always_comb begin
        level_d = level_q;
        if (inc && !at_max) begin
            level_d = level_q + 4'd1;
        end else if (dec && !at_zero) begin
            level_d = level_q - 4'd1;
        end else begin
            level_d = level_q;
        end
    end

    // Level register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 4'd0;
        end else begin
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/room_sequencer.sv
// Room-to-room transition sequencer: edge-exit detection, fade out/in, room swap
// with player reposition, and per-room sticky enemy kills. Optional macro LOCKED_DOORS_EN.
module room_sequencer
    import game_pkg::*;
#(
    parameter int NUM_ROOMS  = 4,
    parameter int EDGE_R_X   = 590,
    parameter int EDGE_L_X   = 40,
    parameter int ENTRY_L_X  = 60,
    parameter int ENTRY_R_X  = 560,
    parameter int ENTRY_Y    = 230,
    parameter int DOOR_Y_MIN = 180,
    parameter int DOOR_Y_MAX = 300,
    parameter int FADE_STEPS = 16
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic [2:0] enemy_dead,
    output logic [1:0] room_idx,
    output logic       freeze,
    output logic       load_pos,
    output logic [9:0] load_x,
    output logic [9:0] load_y,
    output logic [3:0] fade_level,
    output logic [2:0] enemy_enable,
    output logic       room_cleared
);

    localparam logic [1:0] LAST_ROOM = 2'(NUM_ROOMS - 1);

    room_state_t state_q, state_d;
    dir_t        dir_q, dir_d;
    logic [1:0]  room_q, room_d;
    logic [9:0]  load_x_q, load_x_d;
    logic [9:0]  load_y_q, load_y_d;
    logic [MAX_ROOMS-1:0][NUM_ENEMIES-1:0] killed_q, killed_d;

    logic       fade_inc_s;
    logic       fade_dec_s;
    logic       fade_at_max_s;
    logic       fade_at_zero_s;
    logic [3:0] fade_level_s;
    logic       in_door_s;
    logic       right_exit_s;
    logic       left_exit_s;
    logic       cleared_s;

    fade_counter #(
        .MAX_LEVEL (FADE_STEPS - 1)
    ) u_fade (
        .clk     (frame_clk),
        .rst     (Reset),
        .inc     (fade_inc_s),
        .dec     (fade_dec_s),
        .level   (fade_level_s),
        .at_max  (fade_at_max_s),
        .at_zero (fade_at_zero_s)
    );

    assign cleared_s = &killed_q[room_q];
    assign in_door_s = in_window(player_y, 10'(DOOR_Y_MIN), 10'(DOOR_Y_MAX));

`ifdef LOCKED_DOORS_EN
    assign right_exit_s = (player_x > 10'(EDGE_R_X)) && in_door_s
                          && (room_q < LAST_ROOM) && cleared_s;
`else
    assign right_exit_s = (player_x > 10'(EDGE_R_X)) && in_door_s
                          && (room_q < LAST_ROOM);
`endif
    assign left_exit_s  = (player_x < 10'(EDGE_L_X)) && in_door_s
                          && (room_q != 2'd0);

    // Next-state, room swap and kill bookkeeping.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        room_d     = room_q;
        load_x_d   = load_x_q;
        load_y_d   = load_y_q;
        killed_d   = killed_q;
        fade_inc_s = 1'b0;
        fade_dec_s = 1'b0;
        case (state_q)
            PLAY: begin
                killed_d[room_q] = killed_q[room_q] | enemy_dead;
                if (right_exit_s) begin
                    state_d    = FADE_OUT;
                    dir_d      = DIR_R;
                    fade_inc_s = 1'b1;
                end else if (left_exit_s) begin
                    state_d    = FADE_OUT;
                    dir_d      = DIR_L;
                    fade_inc_s = 1'b1;
                end else begin
                    state_d = PLAY;
                end
            end
            FADE_OUT: begin
                if (fade_at_max_s) begin
                    state_d  = SWAP;
                    load_y_d = 10'(ENTRY_Y);
                    if (dir_q == DIR_R) begin
                        room_d   = room_q + 2'd1;
                        load_x_d = 10'(ENTRY_L_X);
                    end else begin
                        room_d   = room_q - 2'd1;
                        load_x_d = 10'(ENTRY_R_X);
                    end
                end else begin
                    fade_inc_s = 1'b1;
                end
            end
            // Level stays at black across SWAP and the first FADE_IN frame.
            SWAP: begin
                state_d = FADE_IN;
            end
            FADE_IN: begin
                if (fade_at_zero_s) begin
                    state_d = PLAY;
                end else begin
                    fade_dec_s = 1'b1;
                end
            end
            default: begin
                state_d = PLAY;
            end
        endcase
    end

    // Sequencer state registers with synchronous reset.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q  <= PLAY;
            dir_q    <= DIR_R;
            room_q   <= 2'd0;
            load_x_q <= 10'(ENTRY_L_X);
            load_y_q <= 10'(ENTRY_Y);
            killed_q <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            room_q   <= room_d;
            load_x_q <= load_x_d;
            load_y_q <= load_y_d;
            killed_q <= killed_d;
        end
    end

    assign room_idx     = room_q;
    assign freeze       = (state_q != PLAY);
    assign load_pos     = (state_q == SWAP);
    assign load_x       = load_x_q;
    assign load_y       = load_y_q;
    assign fade_level   = fade_level_s;
    assign enemy_enable = (state_q == PLAY) ? ~killed_q[room_q] : 3'b000;
    assign room_cleared = cleared_s;

endmodule

// File: tb/tb_room_sequencer.sv
// Scoreboard bench for room_sequencer: a frame-level reference model pushes the
// expected outputs for every frame; a monitor pops and compares after each edge.
module tb_room_sequencer;

    localparam int NR = 4;
    localparam int FS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] px = 10'd320;
    logic [9:0] py = 10'd230;
    logic [2:0] dead = 3'b000;

    logic [1:0] room_idx;
    logic       freeze, load_pos, room_cleared;
    logic [9:0] load_x, load_y;
    logic [3:0] fade_level;
    logic [2:0] enemy_enable;

    always #5 clk = ~clk;

    room_sequencer dut (
        .frame_clk    (clk),
        .Reset        (rst),
        .player_x     (px),
        .player_y     (py),
        .enemy_dead   (dead),
        .room_idx     (room_idx),
        .freeze       (freeze),
        .load_pos     (load_pos),
        .load_x       (load_x),
        .load_y       (load_y),
        .fade_level   (fade_level),
        .enemy_enable (enemy_enable),
        .room_cleared (room_cleared)
    );

    typedef struct packed {
        logic [1:0] room;
        logic       frz;
        logic       lp;
        logic [9:0] lx;
        logic [9:0] ly;
        logic [3:0] fade;
        logic [2:0] en;
        logic       clr;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: a transition is a frame count t since the exit edge.
    int         m_room = 0;
    int         m_t    = -1;
    bit         m_right = 1'b1;
    logic [2:0] m_killed [NR];
    int         m_lx = 60;
    int         m_ly = 230;

    function automatic obs_t model_outputs();
        obs_t o;
        o.room = 2'(m_room);
        o.frz  = (m_t >= 0);
        o.lp   = (m_t == FS - 1);
        o.lx   = 10'(m_lx);
        o.ly   = 10'(m_ly);
        if (m_t < 0)            o.fade = 4'd0;
        else if (m_t < FS - 1)  o.fade = 4'(m_t + 1);
        else if (m_t == FS - 1) o.fade = 4'(FS - 1);
        else                    o.fade = 4'(2 * FS - 1 - m_t);
        o.en  = (m_t < 0) ? ~m_killed[m_room] : 3'b000;
        o.clr = &m_killed[m_room];
        return o;
    endfunction

    task automatic model_step(input int x, input int y, input logic [2:0] d, input bit r);
        bit door, rx, lx, cleared;
        if (r) begin
            m_room = 0; m_t = -1; m_lx = 60; m_ly = 230;
            for (int i = 0; i < NR; i++) m_killed[i] = 3'b000;
        end else if (m_t < 0) begin
            door    = (y >= 180) && (y <= 300);
            cleared = &m_killed[m_room];
            rx = (x > 590) && door && (m_room < NR - 1);
`ifdef LOCKED_DOORS_EN
            rx = rx && cleared;
`endif
            lx = (x < 40) && door && (m_room > 0);
            m_killed[m_room] = m_killed[m_room] | d;
            if (rx) begin
                m_t = 0; m_right = 1'b1;
            end else if (lx) begin
                m_t = 0; m_right = 1'b0;
            end
        end else begin
            m_t++;
            if (m_t == FS - 1) begin
                m_room = m_right ? m_room + 1 : m_room - 1;
                m_lx   = m_right ? 60 : 560;
                m_ly   = 230;
            end
            if (m_t == 2 * FS) m_t = -1;
        end
    endtask

    // One frame: drive inputs away from the edge, advance the model, queue the expectation.
    task automatic tick(input int x, input int y, input logic [2:0] d, input bit r);
        @(negedge clk);
        px = 10'(x); py = 10'(y); dead = d; rst = r;
        model_step(x, y, d, r);
        exp_q.push_back(model_outputs());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(320, 230, 3'b000, 1'b0);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(posedge clk) begin
        obs_t act, ex;
        #1;
        if (exp_q.size() > 0) begin
            ex  = exp_q.pop_front();
            act = '{room_idx, freeze, load_pos, load_x, load_y,
                    fade_level, enemy_enable, room_cleared};
            n_checks++;
            if (act === ex) begin
                n_pass++;
            end else begin
                $display("FAIL frame_outputs t=%0t actual room=%0d frz=%0b lp=%0b lx=%0d ly=%0d fade=%0d en=%b clr=%0b required room=%0d frz=%0b lp=%0b lx=%0d ly=%0d fade=%0d en=%b clr=%0b",
                         $time, act.room, act.frz, act.lp, act.lx, act.ly, act.fade, act.en, act.clr,
                         ex.room, ex.frz, ex.lp, ex.lx, ex.ly, ex.fade, ex.en, ex.clr);
            end
        end
    end

    initial begin
        int x, y;
        logic [2:0] d;
        for (int i = 0; i < NR; i++) m_killed[i] = 3'b000;

        tick(320, 230, 3'b000, 1'b1);
        tick(320, 230, 3'b000, 1'b1);
        idle(2);
        // Left exit from room 0 is ignored.
        for (int i = 0; i < 3; i++) tick(30, 230, 3'b000, 1'b0);
        // Right exit into room 1, full transition.
        tick(600, 230, 3'b000, 1'b0);
        idle(34);
        // Left edge outside the door window, then inside.
        for (int i = 0; i < 3; i++) tick(30, 100, 3'b000, 1'b0);
        tick(30, 200, 3'b000, 1'b0);
        idle(34);
        // Back to room 1, kill enemy 1, visit room 2, return.
        tick(600, 230, 3'b000, 1'b0);
        idle(34);
        tick(320, 230, 3'b010, 1'b0);
        idle(2);
        tick(600, 250, 3'b000, 1'b0);
        idle(34);
        tick(20, 250, 3'b000, 1'b0);
        idle(34);
        // Both edges at once cannot happen on one X, so exercise the room-3 right edge.
        tick(600, 230, 3'b000, 1'b0);
        idle(34);
        tick(600, 230, 3'b000, 1'b0);
        idle(34);
        for (int i = 0; i < 3; i++) tick(600, 230, 3'b000, 1'b0);
        // Reset during FADE_OUT.
        tick(20, 230, 3'b000, 1'b0);
        idle(4);
        tick(320, 230, 3'b000, 1'b1);
        idle(3);
        // Locked-door scenario: two kills block the exit, the third unlocks it.
        tick(320, 230, 3'b011, 1'b0);
        for (int i = 0; i < 2; i++) tick(600, 230, 3'b000, 1'b0);
        tick(600, 230, 3'b100, 1'b0);
        tick(600, 230, 3'b000, 1'b0);
        idle(34);
        // Randomised frames biased towards the edges and door limits.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       x = $urandom_range(585, 639);
                1:       x = $urandom_range(0, 45);
                default: x = $urandom_range(100, 500);
            endcase
            y = $urandom_range(170, 310);
            d = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            tick(x, y, d, ($urandom_range(0, 599) == 0));
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL queue_drain actual %0d pending required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
